// File: rtl/pc_unit_pkg.sv
// Shared encodings for the PC unit: branch ops, exception causes, sequencer states.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    BR_BEQ = 2'b00,
    BR_BNE = 2'b01,
    BR_BLE = 2'b10,
    BR_BGT = 2'b11
  } branch_op_e;

  typedef enum logic [1:0] {
    EXC_OVERFLOW = 2'd0,
    EXC_BAD_OP   = 2'd1,
    EXC_DIV_ZERO = 2'd2,
    EXC_RESERVED = 2'd3
  } exc_cause_e;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_EXC_VEC = 1'b1
  } state_e;

endpackage

// File: rtl/pc_unit_branch_cond.sv
// Combinational branch-condition evaluator shared with the control-unit bench.
module branch_cond
  import pc_unit_pkg::*;
(
  input  logic [1:0] branchOp,
  input  logic       zero,
  input  logic       gt,
  output logic       cond
);

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cond = 1'b0;
    case (branch_op_e'(branchOp))
      BR_BEQ:  cond = zero;
      BR_BNE:  cond = !zero;
      BR_BLE:  cond = zero | !gt;
      BR_BGT:  cond = gt;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// PC and EPC registers with a RUN/EXC_VEC exception sequencer.
// Optional misaligned-target suppression is enabled by defining PC_ALIGN_CHECK_EN.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcSourceOut,
  input  logic        pcWrite,
  input  logic        pcWriteCond,
  input  logic [1:0]  branchOp,
  input  logic        zero,
  input  logic        gt,
  input  logic        excReq,
  input  logic [1:0]  excCause,
  output logic [31:0] pcOut,
  output logic [31:0] epcOut,
  output logic [1:0]  causeOut,
  output logic        excBusy,
  output logic        branchTaken,
  output logic        alignErr
);

  state_e state_q, state_d;
  logic   cond, wen, align_ok;
  logic   pc_load, epc_load, bt_d, ae_d;

  branch_cond u_branch_cond (
    .branchOp (branchOp),
    .zero     (zero),
    .gt       (gt),
    .cond     (cond)
  );

  assign wen = pcWrite | (pcWriteCond & cond);

`ifdef PC_ALIGN_CHECK_EN
  assign align_ok = (pcSourceOut[1:0] == 2'b00);
`else
  assign align_ok = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (excReq)  state_d = ST_EXC_VEC;
      ST_EXC_VEC: if (pcWrite) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_comb begin
    excBusy = (state_q == ST_EXC_VEC);
  end

  // Exception entry wins over any RUN-state write; the vector write skips the alignment check.
  always_comb begin
    pc_load  = 1'b0;
    epc_load = 1'b0;
    bt_d     = 1'b0;
    ae_d     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (excReq) begin
          epc_load = 1'b1;
        end else if (wen) begin
          pc_load = align_ok;
          ae_d    = !align_ok;
          bt_d    = align_ok & !pcWrite;
        end
      end
      ST_EXC_VEC: pc_load = pcWrite;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcOut       <= RESET_PC;
      epcOut      <= 32'h0;
      causeOut    <= 2'b00;
      branchTaken <= 1'b0;
    end else begin
      if (pc_load)  pcOut <= pcSourceOut;
      if (epc_load) begin
        epcOut   <= pcOut - EPC_OFFSET;
        causeOut <= excCause;
      end
      branchTaken <= bt_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) alignErr <= 1'b0;
    else       alignErr <= ae_d;
  end
`else
  assign alignErr = 1'b0;
  logic unused_ae;
  assign unused_ae = ae_d;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes expected post-edge state, a monitor pops and compares.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcSourceOut;
  logic        pcWrite, pcWriteCond, zero, gt, excReq;
  logic [1:0]  branchOp, excCause;
  logic [31:0] pcOut, epcOut;
  logic [1:0]  causeOut;
  logic        excBusy, branchTaken, alignErr;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        busy;
    logic        bt;
    logic        ae;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pcSourceOut (pcSourceOut),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .branchOp    (branchOp),
    .zero        (zero),
    .gt          (gt),
    .excReq      (excReq),
    .excCause    (excCause),
    .pcOut       (pcOut),
    .epcOut      (epcOut),
    .causeOut    (causeOut),
    .excBusy     (excBusy),
    .branchTaken (branchTaken),
    .alignErr    (alignErr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // One cycle of stimulus; the expected values describe the outputs after the next rising edge.
  task automatic step(input string name, input logic rst, input logic pw, input logic pwc,
                      input logic [1:0] bop, input logic z, input logic g,
                      input logic er, input logic [1:0] ec, input logic [31:0] src,
                      input logic [31:0] e_pc, input logic [31:0] e_epc, input logic [1:0] e_cause,
                      input logic e_busy, input logic e_bt, input logic e_ae);
    exp_t e;
    @(negedge clk);
    reset = rst; pcWrite = pw; pcWriteCond = pwc; branchOp = bop;
    zero = z; gt = g; excReq = er; excCause = ec; pcSourceOut = src;
    e.name = name; e.pc = e_pc; e.epc = e_epc; e.cause = e_cause;
    e.busy = e_busy; e.bt = e_bt; e.ae = e_ae;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".pc"},    pcOut,              e.pc);
        check({e.name, ".epc"},   epcOut,             e.epc);
        check({e.name, ".cause"}, {30'h0, causeOut},  {30'h0, e.cause});
        check({e.name, ".busy"},  {31'h0, excBusy},   {31'h0, e.busy});
        check({e.name, ".bt"},    {31'h0, branchTaken}, {31'h0, e.bt});
        check({e.name, ".ae"},    {31'h0, alignErr},  {31'h0, e.ae});
      end
    end
  end

  initial begin : stimulus
    logic [31:0] mis_pc;
    logic        mis_ae;
`ifdef PC_ALIGN_CHECK_EN
    mis_pc = 32'h8;  mis_ae = 1'b1;
`else
    mis_pc = 32'h42; mis_ae = 1'b0;
`endif
    reset = 1'b1; pcWrite = 0; pcWriteCond = 0; branchOp = 0; zero = 0; gt = 0;
    excReq = 0; excCause = 0; pcSourceOut = 0;
    //    name        rst pw pwc bop  z  g  er ec  src             pc            epc           ca  bsy bt ae
    step("reset",     1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0004, 32'h0,        32'h0,        2'd0, 0, 0, 0);
    step("wr4",       0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0004, 32'h4,        32'h0,        2'd0, 0, 0, 0);
    step("idle1",     0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0000, 32'h4,        32'h0,        2'd0, 0, 0, 0);
    step("bne_nt",    0, 0, 1, 2'd1, 1, 0, 0, 2'd0, 32'h0000_0040, 32'h4,        32'h0,        2'd0, 0, 0, 0);
    step("bne_t",     0, 0, 1, 2'd1, 0, 0, 0, 2'd0, 32'h0000_0040, 32'h40,       32'h0,        2'd0, 0, 1, 0);
    step("bt_pulse",  0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0000, 32'h40,       32'h0,        2'd0, 0, 0, 0);
    step("wr100",     0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0100, 32'h100,      32'h0,        2'd0, 0, 0, 0);
    step("exc_ent",   0, 1, 0, 2'd0, 0, 0, 1, 2'd2, 32'h0000_0200, 32'h100,      32'hFC,       2'd2, 1, 0, 0);
    step("exc_nest",  0, 0, 1, 2'd0, 1, 0, 1, 2'd1, 32'h0000_0300, 32'h100,      32'hFC,       2'd2, 1, 0, 0);
    step("exc_vec",   0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_00FD, 32'hFD,       32'hFC,       2'd2, 0, 0, 0);
    step("wr0",       0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0000, 32'h0,        32'hFC,       2'd2, 0, 0, 0);
    step("exc_wrap",  0, 0, 0, 2'd0, 0, 0, 1, 2'd1, 32'h0000_0000, 32'h0,        32'hFFFF_FFFC, 2'd1, 1, 0, 0);
    step("vec8",      0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0008, 32'h8,        32'hFFFF_FFFC, 2'd1, 0, 0, 0);
    step("mis42",     0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0042, mis_pc,       32'hFFFF_FFFC, 2'd1, 0, 0, mis_ae);
    step("ae_pulse",  0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0000, mis_pc,       32'hFFFF_FFFC, 2'd1, 0, 0, 0);
    step("ble_nt",    0, 0, 1, 2'd2, 0, 1, 0, 2'd0, 32'h0000_0080, mis_pc,       32'hFFFF_FFFC, 2'd1, 0, 0, 0);
    step("ble_t",     0, 0, 1, 2'd2, 0, 0, 0, 2'd0, 32'h0000_0080, 32'h80,       32'hFFFF_FFFC, 2'd1, 0, 1, 0);
    step("bgt_t",     0, 0, 1, 2'd3, 0, 1, 0, 2'd0, 32'h0000_0090, 32'h90,       32'hFFFF_FFFC, 2'd1, 0, 1, 0);
    step("bgt_nt",    0, 0, 1, 2'd3, 1, 0, 0, 2'd0, 32'h0000_0094, 32'h90,       32'hFFFF_FFFC, 2'd1, 0, 0, 0);
    step("beq_t",     0, 0, 1, 2'd0, 1, 0, 0, 2'd0, 32'h0000_00A0, 32'hA0,       32'hFFFF_FFFC, 2'd1, 0, 1, 0);
    step("both_wr",   0, 1, 1, 2'd0, 1, 0, 0, 2'd0, 32'h0000_00B0, 32'hB0,       32'hFFFF_FFFC, 2'd1, 0, 0, 0);
    step("exc_3",     0, 0, 0, 2'd0, 0, 0, 1, 2'd3, 32'h0000_0000, 32'hB0,       32'hAC,       2'd3, 1, 0, 0);
    step("hold_vec",  0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0000, 32'hB0,       32'hAC,       2'd3, 1, 0, 0);
    step("rst_exc",   1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0000, 32'h0,        32'h0,        2'd0, 0, 0, 0);
    step("run_again", 0, 0, 1, 2'd1, 0, 0, 0, 2'd0, 32'h0000_0014, 32'h14,       32'h0,        2'd0, 0, 1, 0);
    step("idle_end",  0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0000, 32'h14,       32'h0,        2'd0, 0, 0, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter and exception-PC register unit for the multicycle core. It sits directly downstream of the PC source mux, latching the selected next-PC under unconditional, branch-conditional or exception-vector control. It also owns the EPC register, which feeds back into that same mux as the return-from-exception source. A two-state exception sequencer makes EPC capture and vector load atomic with respect to ordinary PC writes.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset
- EPC_OFFSET, 32'd4, subtracted from PC when EPC is captured (PC is already incremented at fetch)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- pcSourceOut  in  32  next-PC candidate from the PC source mux
- pcWrite  in  1  unconditional PC write request
- pcWriteCond  in  1  conditional (branch) PC write request
- branchOp  in  2  00 beq, 01 bne, 10 ble, 11 bgt
- zero  in  1  ALU zero flag
- gt  in  1  ALU greater-than flag
- excReq  in  1  exception request from control (overflow, bad opcode, div-by-zero)
- excCause  in  2  cause code, latched with EPC
- pcOut  out  32  current PC
- epcOut  out  32  saved exception PC, to PC source mux
- causeOut  out  2  latched cause
- excBusy  out  1  high while in EXC_VEC
- branchTaken  out  1  one-cycle pulse: a conditional write was performed
- alignErr  out  1  one-cycle pulse: write suppressed, misaligned target (see Configuration)

## Operation
- Branch condition: beq = zero; bne = !zero; ble = zero | !gt; bgt = gt.
- Write enable in RUN: wen = pcWrite | (pcWriteCond & cond). pcWrite takes priority; with both high, the write is counted as unconditional and branchTaken stays 0.
- FSM states RUN, EXC_VEC:
  - RUN, excReq=1: epcOut <= pcOut - EPC_OFFSET (mod 2^32); causeOut <= excCause; PC is not written even if wen=1; next state EXC_VEC.
  - RUN, excReq=0: if wen, pcOut <= pcSourceOut.
  - EXC_VEC: excBusy=1; pcWriteCond and excReq are ignored. Nested exceptions are dropped and not queued.
  - EXC_VEC, pcWrite=1: pcOut <= pcSourceOut, unconditionally with no alignment check; next state RUN.
- epcOut and causeOut are written only on the RUN -> EXC_VEC transition and otherwise hold.
- Wrap-around: pcOut = 0 with EPC_OFFSET = 4 gives epcOut = 32'hFFFF_FFFC.

## Timing
- Reset values: pcOut = RESET_PC, epcOut = 0, causeOut = 0, excBusy = 0, branchTaken = 0, alignErr = 0, state RUN.
- Reset asserted mid-exception returns the unit to RUN with reset values at the next edge.
- Latency is 1 cycle. A write requested in cycle N is visible on pcOut in cycle N+1.
- branchTaken and alignErr are registered and asserted in cycle N+1 for exactly one cycle.
- excBusy rises the cycle after excReq is accepted and falls the cycle after the vector pcWrite.
- The minimum exception sequence is 2 cycles. There is no timeout: EXC_VEC holds until pcWrite.

## Configuration
- PC_ALIGN_CHECK_EN defined: a RUN-state write whose pcSourceOut[1:0] != 0 is suppressed. pcOut holds and alignErr pulses. A suppressed conditional write does not pulse branchTaken.
- PC_ALIGN_CHECK_EN undefined: all writes proceed as is, and alignErr is tied 0.

## Structure
- Shared package holds:
  - branchOp encodings BR_BEQ, BR_BNE, BR_BLE, BR_BGT
  - the excCause encodings
  - FSM state constants ST_RUN, ST_EXC_VEC
- Sub-module branch_cond: purely combinational; branchOp, zero, gt -> cond. It is reused by the control-unit testbench.

## Test plan
- Reset, then pcWrite=1 with pcSourceOut=32'h0000_0004 -> pcOut = 0 after reset; pcOut = 4 one cycle after the write; all flags 0.
- pcWriteCond=1, branchOp=01 (bne), zero=1, pcSourceOut=32'h40 -> pcOut unchanged, branchTaken=0. Same stimulus with zero=0 -> pcOut = 32'h40, branchTaken pulses once.
- pcOut=32'h100, excReq=1, excCause=2, pcWrite=1 in the same cycle -> epcOut = 32'hFC, causeOut = 2, pcOut stays 32'h100, excBusy=1. Then pcWrite with pcSourceOut=32'h0000_00FD -> pcOut = 32'hFD (no alignment check), excBusy drops.
- excReq during EXC_VEC -> epcOut and causeOut unchanged, state unchanged.
- pcOut=0, excReq=1 -> epcOut = 32'hFFFF_FFFC.
- PC_ALIGN_CHECK_EN defined, pcWrite with pcSourceOut=32'h0000_0042 -> pcOut holds, alignErr pulses one cycle. With the macro undefined -> pcOut = 32'h42.
- Reset asserted in EXC_VEC -> next cycle: state RUN, pcOut = RESET_PC, epcOut = 0.
